// File: rtl/add32_byte_serial_pkg.sv
// Shared ALU definitions: FSM state encoding, slice width and the result flag bundle.
package add32_byte_serial_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/add32_byte_serial_if.sv
// Request/result handshake bundle for the byte-serial adder.
interface add32_byte_serial_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

endinterface

// File: rtl/add32_byte_serial_sparse.sv
// 8-bit Kogge-Stone adder slice with carry-in folded into bit 0's generate term.
module sparse
  import add32_byte_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [7:0] w_p0, w_g0, w_g1, w_g2, w_g3;
  logic [7:2] w_p1;
  logic [7:4] w_p2;

  assign w_p0 = i_a ^ i_b;
  assign w_g0 = (i_a & i_b) | {7'd0, w_p0[0] & i_cin};

  // Three prefix levels of span 2, 4, 8; group-propagate kept only where a later level reads it
  for (genvar i = 0; i < 8; i++) begin : g_prefix
    if (i >= 1) begin : g_l1
      assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
    end else begin : g_l1_pass
      assign w_g1[i] = w_g0[i];
    end
    if (i >= 2) begin : g_l2
      assign w_p1[i] = w_p0[i] & w_p0[i-1];
      assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
    end else begin : g_l2_pass
      assign w_g2[i] = w_g1[i];
    end
    if (i >= 4) begin : g_l3
      assign w_p2[i] = w_p1[i] & w_p1[i-2];
      assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
    end else begin : g_l3_pass
      assign w_g3[i] = w_g2[i];
    end
  end

  assign o_sum  = w_p0 ^ {w_g3[6:0], i_cin};
  assign o_cout = w_g3[7];

endmodule

// File: rtl/add32_byte_serial.sv
// Byte-serial WIDTH-bit adder/subtractor: one operand pair is pushed through a single
// 8-bit slice LSB byte first, with the carry registered between bytes.
module add32_byte_serial
  import add32_byte_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  add32_byte_serial_if.slave bus
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = $clog2(N);
  localparam int MSB   = WIDTH - 1;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_sum;
  logic               r_carry;
  flags_t             r_flags, w_flags_next;
  logic [SLICE_W-1:0] w_slice_a, w_slice_b, w_slice_sum;
  logic               w_slice_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_final;

  assign w_slice_a = r_op_a[r_idx*SLICE_W +: SLICE_W];
  assign w_slice_b = r_op_b[r_idx*SLICE_W +: SLICE_W];

  sparse u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign w_last      = (r_idx == IDX_W'(N - 1));
  assign w_sum_final = {w_slice_sum, r_sum[WIDTH-SLICE_W-1:0]};

  // Flags see the complete sum: the top byte comes straight from the slice on the last step
  always_comb begin
    w_flags_next.cout = w_slice_cout;
    w_flags_next.ovf  = (r_op_a[MSB] == r_op_b[MSB]) && (w_slice_sum[SLICE_W-1] != r_op_a[MSB]);
    w_flags_next.zero = ~|w_sum_final;
    w_flags_next.neg  = w_sum_final[MSB];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)        w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op_a  <= bus.in_a;
            r_op_b  <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) r_flags <= w_flags_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_flags.cout;
  assign bus.out_ovf   = r_flags.ovf;
  assign bus.out_zero  = r_flags.zero;
  assign bus.out_neg   = r_flags.neg;

endmodule

// File: tb/tb_add32_byte_serial.sv
// Directed and random bench for add32_byte_serial against an integer-arithmetic reference.
module tb_add32_byte_serial;

  logic clk = 1'b0;
  logic rst_n;

  add32_byte_serial_if #(.WIDTH(32)) bus ();

  add32_byte_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_sum;
  logic [3:0]  exp_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; flags packed {cout, ovf, zero, neg}
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin);
    longint sa, sb, sr;
    logic   cout, ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      exp_sum = a - b;
      cout    = (a >= b);
      sr      = sa - sb;
    end else begin
      exp_sum = a + b + {31'd0, cin};
      cout    = ((64'(a) + 64'(b) + 64'(cin)) >> 32) != 0;
      sr      = sa + sb + longint'(cin);
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    exp_flags = {cout, ovf, exp_sum == 32'd0, exp_sum[31]};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg};
  endfunction

  // Waits for in_ready, passes the accepting edge, then scrambles the request lines
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic cin);
    int n = 0;
    bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_cin = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom; bus.in_b = $urandom;
    bus.in_sub = 1'($urandom); bus.in_cin = 1'($urandom);
    model(a, b, sub, cin);
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!bus.out_valid && lat < 12) begin
      check({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_sum"}, bus.out_sum, exp_sum);
    check({tag, "_flags"}, {28'd0, dut_flags()}, {28'd0, exp_flags});
  endtask

  task automatic hold(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_hold_sum"}, bus.out_sum, exp_sum);
      check({tag, "_hold_flags"}, {28'd0, dut_flags()}, {28'd0, exp_flags});
    end
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic sub, input logic cin);
    send(a, b, sub, cin);
    wait_result(tag);
    drain(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_sum"}, bus.out_sum, 32'd0);
    check({tag, "_flags"}, {28'd0, dut_flags()}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs, rc;
    int          bp;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_cin = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op("add_byte_carry", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    op("ripple",         32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    op("cin_only",       32'h00000000, 32'h00000000, 1'b0, 1'b1);
    check("cin_only_abs", exp_sum, 32'h00000001);
    op("ovf_pos",        32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    op("ovf_neg",        32'h80000000, 32'h80000000, 1'b0, 1'b0);
    op("sub_5_7",        32'd5,        32'd7,        1'b1, 1'b0);
    op("sub_7_5",        32'd7,        32'd5,        1'b1, 1'b1);
    op("sub_ovf",        32'h80000000, 32'h00000001, 1'b1, 1'b0);

    // Backpressure, then a second request held pending through the handshake
    send(32'h0000FFFF, 32'h00FF0001, 1'b0, 1'b1);
    wait_result("bp");
    hold("bp", 3);
    bus.in_a = 32'hDEADBEEF; bus.in_b = 32'h21524111; bus.in_sub = 1'b1; bus.in_cin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    check("b2b_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    check("b2b_accepted", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    bus.in_a = $urandom; bus.in_b = $urandom;
    model(32'hDEADBEEF, 32'h21524111, 1'b1, 1'b0);
    wait_result("b2b");
    drain("b2b");

    // Reset after two byte steps
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_rst");
    repeat (3) begin
      @(posedge clk); #1;
      check("midrun_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("after_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    op("after_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    check("after_rst_abs", exp_sum, 32'h23456789);

    // Random operands, sub/cin and backpressure
    for (int t = 0; t < 40; t++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom); rc = 1'($urandom);
      if (t % 8 == 0) rb = ~ra;
      if (t % 8 == 1) rb = ra;
      bp = $urandom_range(0, 3);
      send(ra, rb, rs, rc);
      wait_result("rand");
      hold("rand", bp);
      drain("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add32_byte_serial.md
# add32_byte_serial

Byte-serial 32-bit adder/subtractor that sits directly upstream of the 8-bit sparse Kogge-Stone slice. It accepts one operand pair through a valid/ready handshake and feeds the slice one byte per cycle, least significant first. Carry is registered between bytes, and the full sum is assembled with carry, overflow, zero and negative flags. It lets the ALU reuse one 8-bit adder for wide operations when area matters more than latency.

## Interface
- WIDTH, 32, operand width; must be a multiple of 8 and ≥ 16; N = WIDTH/8 byte steps
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A − B, 0 = A + B
- in_cin  in  1  carry-in for add; ignored when in_sub=1
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- out_ovf  out  1  signed two's-complement overflow
- out_zero  out  1  out_sum == 0
- out_neg  out  1  out_sum[WIDTH−1]

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - When in_valid=1, the block captures:
    - opA = in_a
    - opB = in_sub ? ~in_b : in_b
    - carry = in_sub ? 1 : in_cin
  - It also clears idx to 0 and moves to RUN.
- **RUN**
  - in_ready=0.
  - Each cycle the 8-bit slice adds opA[8·idx+:8] + opB[8·idx+:8] + carry.
  - The slice result is written to sum[8·idx+:8], its carry-out is written to carry, and idx increments.
  - On the step where idx = N−1, the FSM moves to DONE and registers the flags.
- **DONE**
  - out_valid=1 and in_ready=0.
  - On out_ready=1 the FSM returns to IDLE.
- **Flags** (registered together with the last byte)
  - out_cout = carry-out of the final step.
  - out_ovf = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]), using the post-inversion opB.
  - out_zero = ~|sum.
  - out_neg = sum[MSB].
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Inputs are sampled only on the accepting edge. Changes to in_a, in_b, in_sub or in_cin during RUN or DONE have no effect.
- out_sum and the flags are driven from registers.
  - They are stable for the whole of DONE.
  - They keep the last result after returning to IDLE, but are valid only while out_valid=1.
- **Reset** at any time, including mid-RUN:
  - The FSM goes to IDLE and idx to 0.
  - opA, opB, sum and carry clear to 0.
  - All outputs read 0 except in_ready, which is 1.
  - The partial operation is discarded and never presented.
- in_valid asserted outside IDLE is not accepted and is not lost. The upstream holds it, per the valid/ready rule, until in_ready=1.

## Timing
- Let E0 be the rising edge where in_valid && in_ready.
- Edges E1..EN compute bytes 0..N−1.
- out_valid rises after EN, i.e. N edges after acceptance. This is 4 cycles for WIDTH=32.
- Output handshake occurs at the edge where out_valid && out_ready. out_valid and in_ready reflect IDLE after that edge.
- Minimum initiation interval is N+2 cycles: accept, N run steps, and one DONE cycle. A new request can be accepted no earlier than the edge after the output handshake.
- With out_ready held low, DONE persists indefinitely and the outputs do not change.
- The critical path is one 8-bit slice plus the carry and idx registers. The slice input mux is selected by idx.

## Structure
- Shared ALU package holds:
  - the state encoding typedef (IDLE, RUN, DONE)
  - a SLICE_W=8 constant
  - the flag bundle typedef {cout, ovf, zero, neg}
- Sub-module: one instance of the existing 8-bit sparse Kogge-Stone adder `sparse`.
  - Its Cin is driven by the carry register.
  - Its Sum and Cout are captured each RUN cycle.
- The FSM, idx counter, operand/sum registers and flag logic live in add32_byte_serial itself.

## Test plan
- **Add with byte carry:** in_a=0x000000FF, in_b=0x00000001, sub=0, cin=0 → sum 0x00000100, cout=0, ovf=0, zero=0, neg=0. out_valid rises exactly 4 edges after acceptance.
- **Full carry ripple:** in_a=0xFFFFFFFF, in_b=0x00000001, cin=0 → sum 0x00000000, cout=1, zero=1, ovf=0. Add with cin=1 on 0x00000000+0x00000000 → sum 0x00000001.
- **Signed overflow:** 0x7FFFFFFF+0x00000001 → sum 0x80000000, ovf=1, neg=1, cout=0. 0x80000000+0x80000000 → sum 0, ovf=1, cout=1, zero=1.
- **Subtract:**
  - 5−7 → sum 0xFFFFFFFE, cout=0, neg=1, ovf=0.
  - 7−5 → sum 0x00000002, cout=1.
  - 0x80000000−1 → sum 0x7FFFFFFF, ovf=1.
- **Backpressure and back-to-back:**
  - Hold out_ready=0 for 3 cycles in DONE → out_sum and flags unchanged, in_ready=0 throughout.
  - A second pending request with in_valid held high is accepted on the edge after the output handshake. Its result appears 4 edges later.
- **Reset mid-RUN:**
  - Assert rst_n=0 asynchronously after 2 byte steps → in_ready=1 and all other outputs 0 immediately, with no out_valid for the aborted op.
  - After release, 0x12345678+0x11111111 → sum 0x23456789.
